pwm_update_master: RTL and testbench

Avalon-MM master that drives the write-only register slave of the 3-phase centre-aligned PWM modulator. A software or DMA producer supplies compare triples over a valid/ready stream. On each PWM trigger interrupt the block writes the six compare registers, then the update strobe (addr 0xF). This closes the control loop without a CPU write burst inside the interrupt window. Before writing, the block enforces a minimum dead-time between each phase's low and high compare values.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_update_master_if.sv | 23 ++
 rtl/pwm_deadtime_clamp.sv | 25 ++
 rtl/pwm_update_master.sv | 127 ++++++++++++
 tb/tb_pwm_update_master.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM modulator register map and its update master.
package pwm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StStrobe,
    StDone
  } state_e;

  localparam int unsigned NUM_WORDS = 6;

  // Compare words in write order: low0, high0, low1, high1, low2, high2.
  typedef logic [NUM_WORDS-1:0][15:0] word_arr_t;

  localparam logic [3:0] ADDR_LOW0   = 4'h0;
  localparam logic [3:0] ADDR_HIGH0  = 4'h1;
  localparam logic [3:0] ADDR_LOW1   = 4'h2;
  localparam logic [3:0] ADDR_HIGH1  = 4'h3;
  localparam logic [3:0] ADDR_LOW2   = 4'h4;
  localparam logic [3:0] ADDR_HIGH2  = 4'h5;
  localparam logic [3:0] ADDR_MAXCTR = 4'h8;
  localparam logic [3:0] ADDR_EN     = 4'h9;
  localparam logic [3:0] ADDR_UPDATE = 4'hF;

  localparam logic [15:0] DEADTIME_DEFAULT = 16'd8;

endpackage

// File: rtl/pwm_update_master_if.sv
// Compare-triple stream plus Avalon-MM write bus of the PWM update master.
interface pwm_update_master_if;

  logic        cmp_valid;
  logic        cmp_ready;
  logic [95:0] cmp_data;

  logic [3:0]  M_addr;
  logic        M_write;
  logic [31:0] M_writedata;
  logic        M_waitrequest;

  modport master (
    input  cmp_valid, cmp_data, M_waitrequest,
    output cmp_ready, M_addr, M_write, M_writedata
  );

  modport slave (
    output cmp_valid, cmp_data, M_waitrequest,
    input  cmp_ready, M_addr, M_write, M_writedata
  );

endinterface

// File: rtl/pwm_deadtime_clamp.sv
// Raises a phase's high compare so that high - low is at least DEADTIME.
module pwm_deadtime_clamp
  import pwm_pkg::*;
#(
  parameter logic [15:0] DEADTIME = DEADTIME_DEFAULT
) (
  input  logic [15:0] low,
  input  logic [15:0] high,
  output logic [15:0] high_eff
);

  logic [16:0] min_high;

  always_comb begin
    min_high = {1'b0, low} + {1'b0, DEADTIME};
    if (min_high[16]) begin
      high_eff = 16'hFFFF;
    end else if ({1'b0, high} < min_high) begin
      high_eff = min_high[15:0];
    end else begin
      high_eff = high;
    end
  end

endmodule

// File: rtl/pwm_update_master.sv
// Writes a buffered, dead-time clamped compare triple plus the update strobe on each trigger.
module pwm_update_master
  import pwm_pkg::*;
#(
  parameter logic [15:0] DEADTIME = DEADTIME_DEFAULT,
  parameter int unsigned MISS_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 trig_irq,
  pwm_update_master_if.master  bus,
  output logic                 busy,
  output logic                 update_done,
  output logic                 miss,
  output logic [MISS_W-1:0]    miss_count
);

  localparam logic [MISS_W-1:0] MissOne = 1;
  localparam logic [2:0]        LastIdx = 3'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  word_arr_t         buf_q, work_q, work_d, clamped;
  logic              buf_full_q, buf_full_d;
  logic              release_q;
  logic              start, load, miss_d;
  logic              miss_q;
  logic [MISS_W-1:0] miss_count_q;
  logic              m_write;
  logic [3:0]        m_addr;
  logic [31:0]       m_writedata;

  for (genvar p = 0; p < 3; p++) begin : g_clamp
    pwm_deadtime_clamp #(
      .DEADTIME (DEADTIME)
    ) u_clamp (
      .low      (bus.cmp_data[32*p +: 16]),
      .high     (bus.cmp_data[32*p+16 +: 16]),
      .high_eff (clamped[2*p+1])
    );
    assign clamped[2*p] = bus.cmp_data[32*p +: 16];
  end

  assign load          = bus.cmp_valid && !buf_full_q;
  assign bus.cmp_ready = !buf_full_q;

  // The buffer is released one cycle after its contents move to the working registers.
  always_comb begin
    buf_full_d = buf_full_q;
    if (release_q) buf_full_d = 1'b0;
    if (load)      buf_full_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    work_d      = work_q;
    start       = 1'b0;
    m_write     = 1'b0;
    m_addr      = 4'h0;
    m_writedata = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (trig_irq && en && buf_full_q) begin
          start   = 1'b1;
          work_d  = buf_q;
          idx_d   = 3'd0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        m_write     = 1'b1;
        m_addr      = ADDR_LOW0 + {1'b0, idx_q};
        m_writedata = {16'h0, work_q[idx_q]};
        if (!bus.M_waitrequest) begin
          if (idx_q == LastIdx) state_d = StStrobe;
          else                  idx_d   = idx_q + 3'd1;
        end
      end
      StStrobe: begin
        m_write     = 1'b1;
        m_addr      = ADDR_UPDATE;
        m_writedata = 32'h1;
        if (!bus.M_waitrequest) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Any enabled trigger that does not start a sequence is a miss.
  assign miss_d = trig_irq && en && !start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      work_q       <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      release_q    <= 1'b0;
      miss_q       <= 1'b0;
      miss_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      work_q     <= work_d;
      buf_full_q <= buf_full_d;
      release_q  <= start;
      miss_q     <= miss_d;
      if (load) buf_q <= clamped;
      if (miss_d && !(&miss_count_q)) miss_count_q <= miss_count_q + MissOne;
    end
  end

  assign bus.M_write     = m_write;
  assign bus.M_addr      = m_addr;
  assign bus.M_writedata = m_writedata;
  assign busy            = (state_q != StIdle);
  assign update_done     = (state_q == StDone);
  assign miss            = miss_q;
  assign miss_count      = miss_count_q;

endmodule

// File: tb/tb_pwm_update_master.sv
// Scoreboard bench: expected Avalon writes are queued by stimulus and checked by a bus monitor.
module tb_pwm_update_master;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        trig_irq;
  logic        busy, update_done, miss;
  logic [15:0] miss_count;
  logic        s_busy, s_update_done, s_miss;
  logic [2:0]  s_miss_count;

  int  vectors;
  int  miscompares;
  wr_t exp_q[$];
  logic stall_arm;
  int   stall_cnt;

  pwm_update_master_if bus ();
  pwm_update_master_if sbus ();

  pwm_update_master u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .trig_irq    (trig_irq),
    .bus         (bus),
    .busy        (busy),
    .update_done (update_done),
    .miss        (miss),
    .miss_count  (miss_count)
  );

  // Narrow counter instance: never fed data, so every enabled trigger is a miss.
  pwm_update_master #(
    .MISS_W (3)
  ) u_small (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .trig_irq    (trig_irq),
    .bus         (sbus),
    .busy        (s_busy),
    .update_done (s_update_done),
    .miss        (s_miss),
    .miss_count  (s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic [15:0] l0, h0, l1, h1, l2, h2);
    return {h2, l2, h1, l1, h0, l0};
  endfunction

  task automatic push_words(input logic [15:0] w0, w1, w2, w3, w4, w5);
    logic [15:0] w [6];
    w = '{w0, w1, w2, w3, w4, w5};
    for (int i = 0; i < 6; i++) exp_q.push_back('{addr: 4'(i), data: {16'h0, w[i]}});
    exp_q.push_back('{addr: 4'hF, data: 32'h1});
  endtask

  task automatic load(input logic [95:0] d);
    int n = 0;
    while (!bus.cmp_ready && n < 20) begin
      tick();
      n++;
    end
    check("load_ready", 32'(bus.cmp_ready), 32'd1);
    bus.cmp_valid = 1'b1;
    bus.cmp_data  = d;
    tick();
    bus.cmp_valid = 1'b0;
    check("ready_after_load", 32'(bus.cmp_ready), 32'd0);
  endtask

  task automatic run_seq(input int exp_lat, input int extra_at, input logic [15:0] exp_mc);
    int n;
    trig_irq = 1'b1;
    tick();
    trig_irq = 1'b0;
    n = 1;
    check("busy_started", 32'(busy), 32'd1);
    while (!update_done && n < 40) begin
      if (n == 1) check("ready_T1", 32'(bus.cmp_ready), 32'd0);
      if (n == 2) check("ready_T2", 32'(bus.cmp_ready), 32'd1);
      if (extra_at != 0 && n == extra_at) trig_irq = 1'b1;
      if (extra_at != 0 && n == extra_at + 1) begin
        trig_irq = 1'b0;
        check("busy_miss_pulse", 32'(miss), 32'd1);
        check("busy_miss_count", 32'(miss_count), 32'(exp_mc));
      end
      tick();
      n++;
    end
    trig_irq = 1'b0;
    check("done_latency", 32'(n), 32'(exp_lat));
    check("busy_at_done", 32'(busy), 32'd1);
    tick();
    check("idle_after_done", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every presented write is compared to the queue head; held writes must stay stable.
  always @(negedge clk) begin
    if (reset_n && bus.M_write) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.M_addr, bus.M_writedata);
      end else begin
        if (bus.M_addr !== exp_q[0].addr || bus.M_writedata !== exp_q[0].data) begin
          miscompares++;
          $display("FAIL bus_write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.M_addr, bus.M_writedata, exp_q[0].addr, exp_q[0].data);
        end
        if (!bus.M_waitrequest) void'(exp_q.pop_front());
      end
    end
  end

  // Stalls the addr2 write for three cycles when armed.
  always @(posedge clk) begin
    #2;
    if (stall_arm && bus.M_write && bus.M_addr == 4'd2 && stall_cnt < 3) begin
      bus.M_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      bus.M_waitrequest = 1'b0;
      if (!stall_arm) stall_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    stall_arm      = 1'b0;
    reset_n        = 1'b0;
    en             = 1'b1;
    trig_irq       = 1'b0;
    bus.cmp_valid  = 1'b0;
    bus.cmp_data   = '0;
    sbus.cmp_valid = 1'b0;
    sbus.cmp_data  = '0;
    sbus.M_waitrequest = 1'b0;
    tick();
    tick();
    check("rst_cmp_ready", 32'(bus.cmp_ready), 32'd1);
    check("rst_write", 32'(bus.M_write), 32'd0);
    check("rst_addr", 32'(bus.M_addr), 32'd0);
    check("rst_wdata", bus.M_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {30'd0, update_done, miss}, 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic sequence, no clamping needed.
    load(mk(16'h0080, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100));
    push_words(16'h0080, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100);
    run_seq(8, 0, 16'd0);

    // Clamping: raise, saturate, untouched.
    load(mk(16'h0200, 16'h0203, 16'hFFFC, 16'h0010, 16'h1000, 16'h2000));
    push_words(16'h0200, 16'h0208, 16'hFFFC, 16'hFFFF, 16'h1000, 16'h2000);
    run_seq(8, 0, 16'd0);

    // Waitrequest for three cycles on addr2; exact-deadtime and zero cases.
    stall_arm = 1'b1;
    load(mk(16'h0010, 16'h0040, 16'h0020, 16'h0025, 16'h0030, 16'h0038));
    push_words(16'h0010, 16'h0040, 16'h0020, 16'h0028, 16'h0030, 16'h0038);
    run_seq(11, 0, 16'd0);
    stall_arm = 1'b0;

    // Miss on empty buffer, then a second miss during a sequence.
    trig_irq = 1'b1;
    tick();
    trig_irq = 1'b0;
    check("empty_miss_pulse", 32'(miss), 32'd1);
    check("empty_miss_count", 32'(miss_count), 32'd1);
    check("empty_no_write", 32'(bus.M_write), 32'd0);
    check("empty_not_busy", 32'(busy), 32'd0);
    tick();
    check("miss_one_cycle", 32'(miss), 32'd0);
    load(mk(16'h0000, 16'h0000, 16'h1000, 16'h0FFF, 16'hFFF7, 16'h0000));
    push_words(16'h0000, 16'h0008, 16'h1000, 16'h1008, 16'hFFF7, 16'hFFFF);
    run_seq(8, 3, 16'd2);

    // Disabled trigger is ignored entirely.
    load(mk(16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555, 16'h0666));
    en = 1'b0;
    trig_irq = 1'b1;
    tick();
    trig_irq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("dis_no_busy", 32'(busy), 32'd0);
      check("dis_no_miss", 32'(miss), 32'd0);
      tick();
    end
    check("dis_miss_count", 32'(miss_count), 32'd2);
    en = 1'b1;

    // Reset during the addr3 write abandons the sequence.
    exp_q.push_back('{addr: 4'h0, data: 32'h0111});
    exp_q.push_back('{addr: 4'h1, data: 32'h0222});
    exp_q.push_back('{addr: 4'h2, data: 32'h0333});
    trig_irq = 1'b1;
    tick();
    trig_irq = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_addr", 32'(bus.M_addr), 32'd3);
    check("pre_rst_write", 32'(bus.M_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_write", 32'(bus.M_write), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(bus.cmp_ready), 32'd1);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("postrst_miss_count", 32'(miss_count), 32'd0);
    load(mk(16'hABC0, 16'hABD0, 16'h0005, 16'h000C, 16'hFFFF, 16'hFFFF));
    push_words(16'hABC0, 16'hABD0, 16'h0005, 16'h000D, 16'hFFFF, 16'hFFFF);
    run_seq(8, 0, 16'd0);

    // Eight more misses: wide counter reaches 8, 3-bit counter holds at 7.
    for (int i = 0; i < 8; i++) begin
      trig_irq = 1'b1;
      tick();
      trig_irq = 1'b0;
      tick();
    end
    check("main_miss_count", 32'(miss_count), 32'd8);
    check("small_miss_sat", 32'(s_miss_count), 32'd7);
    check("end_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
